// File: rtl/arena_tick_engine.sv
// Per-tick board update engine for the light-cycle game: reads each player's target cell,
// resolves deaths, writes trails/collision marks back to the board RAM and can wipe the board.
module arena_tick_engine #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int COLOR_BITS  = 3,
  parameter int WRAP_MODE   = 0
) (
  input  logic                                    CLOCK_50,
  input  logic                                    reset,
  input  logic                                    tick,
  input  logic                                    clear_req,
  input  logic [NUM_PLAYERS*(X_BITS+Y_BITS)-1:0] pos_in,
  input  logic [COLOR_BITS-1:0]                   ram_rdata,
  output logic [X_BITS+Y_BITS-1:0]                ram_addr,
  output logic [COLOR_BITS-1:0]                   ram_wdata,
  output logic                                    ram_wren,
  output logic [NUM_PLAYERS-1:0]                  alive_out,
  output logic                                    busy,
  output logic                                    draw_start,
  output logic                                    game_over,
  output logic                                    overrun
);

  localparam int PW = X_BITS + Y_BITS;
  localparam int AW = X_BITS + Y_BITS;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic [AW-1:0]           ram_addr_r, ram_addr_s;
  logic [COLOR_BITS-1:0]   ram_wdata_r, ram_wdata_s;
  logic                    ram_wren_r, ram_wren_s;
  logic [NUM_PLAYERS-1:0]  alive_r, alive_s;
  logic                    busy_r, busy_s, draw_r, draw_s;
  logic                    game_over_r, game_over_s, overrun_r, overrun_s;
  logic [PW-1:0]           pos_r [NUM_PLAYERS];
  logic [COLOR_BITS-1:0]   occ_r [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  mask_r;
  logic [PW-1:0]           latch_s [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  hit_mask_s, mask_use_s;
  logic [CW-1:0]           tgt_s;
  logic [PW-1:0]           sel_pos_s;
  logic                    sel_alive_s, sel_surv_s, wr_en_s;
  logic [COLOR_BITS-1:0]   sel_color_s, wr_data_s;

  function automatic logic [PW-1:0] fold_pos(input logic [PW-1:0] p);
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    x = p[PW-1:Y_BITS];
    y = p[Y_BITS-1:0];
    if (x == {X_BITS{1'b1}}) x = X_BITS'(X_MAX - 1);
    else if (x >= X_BITS'(X_MAX)) x = '0;
    else x = x;
    if (y == {Y_BITS{1'b1}}) y = Y_BITS'(Y_MAX - 1);
    else if (y >= Y_BITS'(Y_MAX)) y = '0;
    else y = y;
    return {x, y};
  endfunction

  function automatic logic in_bounds(input logic [PW-1:0] p);
    return (p[PW-1:Y_BITS] < X_BITS'(X_MAX)) && (p[Y_BITS-1:0] < Y_BITS'(Y_MAX));
  endfunction

  function automatic int unsigned popcnt(input logic [NUM_PLAYERS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_PLAYERS; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Incoming positions, folded to the opposite edge in wrap mode.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      latch_s[i] = (WRAP_MODE != 0) ? fold_pos(pos_in[i*PW +: PW]) : pos_in[i*PW +: PW];
    end
  end

  // Death resolution: trail hit, head-on with another live player, or off the arena.
  always_comb begin : resolve
    logic hit;
    hit_mask_s = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hit = (occ_r[i] != '0);
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        hit = hit | ((j != i) && alive_r[j] && (pos_r[j] == pos_r[i]));
      end
      hit = hit | ((WRAP_MODE == 0) && !in_bounds(pos_r[i]));
      hit_mask_s[i] = alive_r[i] & ~hit;
    end
  end

  // Selects the player whose address/write is presented on the next cycle.
  always_comb begin
    tgt_s       = (state_r == S_CHECK) ? '0 : cnt_r + CW'(1);
    mask_use_s  = (state_r == S_CHECK) ? hit_mask_s : mask_r;
    sel_pos_s   = '0;
    sel_alive_s = 1'b0;
    sel_surv_s  = 1'b0;
    sel_color_s = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      sel_pos_s   = (tgt_s == CW'(i)) ? pos_r[i]            : sel_pos_s;
      sel_alive_s = (tgt_s == CW'(i)) ? alive_r[i]          : sel_alive_s;
      sel_surv_s  = (tgt_s == CW'(i)) ? mask_use_s[i]       : sel_surv_s;
      sel_color_s = (tgt_s == CW'(i)) ? COLOR_BITS'(i + 1)  : sel_color_s;
    end
    // Off-arena deaths leave no mark; dead-at-latch players never write.
    wr_en_s   = sel_alive_s & (sel_surv_s | in_bounds(sel_pos_s));
    wr_data_s = sel_surv_s ? sel_color_s : {COLOR_BITS{1'b1}};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    ram_wren_s  = 1'b0;
    alive_s     = alive_r;
    draw_s      = 1'b0;
    game_over_s = game_over_r;
    overrun_s   = overrun_r | (tick & (state_r != S_IDLE));
    case (state_r)
      S_IDLE: begin
        if (clear_req) begin
          state_s     = S_CLEAR;
          cnt_s       = '0;
          ram_addr_s  = '0;
          ram_wdata_s = '0;
          ram_wren_s  = 1'b1;
        end else if (tick) begin
          state_s    = S_READ;
          cnt_s      = '0;
          ram_addr_s = latch_s[0];
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        ram_addr_s = sel_pos_s;
        if (cnt_r == CW'(NUM_PLAYERS)) begin
          state_s = S_CHECK;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_CHECK: begin
        state_s     = S_WRITE;
        cnt_s       = '0;
        ram_addr_s  = sel_pos_s;
        ram_wdata_s = wr_data_s;
        ram_wren_s  = wr_en_s;
      end
      S_WRITE: begin
        if (cnt_r == CW'(NUM_PLAYERS - 1)) begin
          state_s     = S_DONE;
          alive_s     = mask_r;
          draw_s      = 1'b1;
          game_over_s = game_over_r | (popcnt(mask_r) <= 32'd1);
        end else begin
          cnt_s       = cnt_r + CW'(1);
          ram_addr_s  = sel_pos_s;
          ram_wdata_s = wr_data_s;
          ram_wren_s  = wr_en_s;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      S_CLEAR: begin
        if (cnt_r == {1'b0, {AW{1'b1}}}) begin
          state_s     = S_DONE;
          alive_s     = '1;
          game_over_s = 1'b0;
          overrun_s   = 1'b0;
          draw_s      = 1'b1;
        end else begin
          cnt_s       = cnt_r + CW'(1);
          ram_addr_s  = cnt_s[AW-1:0];
          ram_wdata_s = '0;
          ram_wren_s  = 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_wren_r  <= 1'b0;
      alive_r     <= '1;
      busy_r      <= 1'b0;
      draw_r      <= 1'b0;
      game_over_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      ram_wren_r  <= ram_wren_s;
      alive_r     <= alive_s;
      busy_r      <= busy_s;
      draw_r      <= draw_s;
      game_over_r <= game_over_s;
      overrun_r   <= overrun_s;
    end
  end

  // Per-player datapath: latched positions, read-back occupancy and the resolved mask.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_r[i] <= '0;
        occ_r[i] <= '0;
      end
      mask_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (tick && !clear_req) pos_r[i] <= latch_s[i];
            else pos_r[i] <= pos_r[i];
          end
        end
        S_READ: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (cnt_r == CW'(i + 1)) occ_r[i] <= ram_rdata;
            else occ_r[i] <= occ_r[i];
          end
        end
        S_CHECK: mask_r <= hit_mask_s;
        default: mask_r <= mask_r;
      endcase
    end
  end

  assign ram_addr   = ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign ram_wren   = ram_wren_r;
  assign alive_out  = alive_r;
  assign busy       = busy_r;
  assign draw_start = draw_r;
  assign game_over  = game_over_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_arena_tick_engine.sv
// Bench for arena_tick_engine: default-size instances in kill and wrap mode share stimulus and
// are checked against a cell-level board model; a tiny instance exercises the board wipe.
module tb_arena_tick_engine;
  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic        reset = 1'b1, tick = 1'b0, clear_req = 1'b0;
  logic [59:0] pos_ab = '0;
  logic [2:0]  rdata_a, rdata_b, wdata_a, wdata_b;
  logic [14:0] addr_a, addr_b;
  logic        wren_a, wren_b, busy_a, busy_b, draw_a, draw_b, go_a, go_b, ovr_a, ovr_b;
  logic [3:0]  alive_a, alive_b;
  logic        tick_c = 1'b0, clear_c = 1'b0;
  logic [19:0] pos_c = '0;
  logic [2:0]  rdata_c, wdata_c;
  logic [4:0]  addr_c;
  logic        wren_c, busy_c, draw_c, go_c, ovr_c;
  logic [3:0]  alive_c;
  logic        pl_we = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [2:0]  pl_data = '0;

  bit [2:0] mem_a [32768];
  bit [2:0] mem_b [32768];
  bit [2:0] mem_c [32];
  bit [2:0] ref_mem [2][32768];
  logic [3:0] alive_m [2];
  bit go_m [2];
  bit ovr_m [2];
  int total = 0, bad = 0;

  arena_tick_engine #(.WRAP_MODE(0)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .clear_req(clear_req), .pos_in(pos_ab),
    .ram_rdata(rdata_a), .ram_addr(addr_a), .ram_wdata(wdata_a), .ram_wren(wren_a),
    .alive_out(alive_a), .busy(busy_a), .draw_start(draw_a), .game_over(go_a), .overrun(ovr_a));
  arena_tick_engine #(.WRAP_MODE(1)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .clear_req(clear_req), .pos_in(pos_ab),
    .ram_rdata(rdata_b), .ram_addr(addr_b), .ram_wdata(wdata_b), .ram_wren(wren_b),
    .alive_out(alive_b), .busy(busy_b), .draw_start(draw_b), .game_over(go_b), .overrun(ovr_b));
  arena_tick_engine #(.X_BITS(3), .Y_BITS(2), .X_MAX(6), .Y_MAX(3)) dut_c (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick_c), .clear_req(clear_c), .pos_in(pos_c),
    .ram_rdata(rdata_c), .ram_addr(addr_c), .ram_wdata(wdata_c), .ram_wren(wren_c),
    .alive_out(alive_c), .busy(busy_c), .draw_start(draw_c), .game_over(go_c), .overrun(ovr_c));

  always @(posedge CLOCK_50) begin
    if (wren_a) mem_a[addr_a] <= wdata_a;
    else if (pl_we) mem_a[pl_addr] <= pl_data;
    rdata_a <= mem_a[addr_a];
  end
  always @(posedge CLOCK_50) begin
    if (wren_b) mem_b[addr_b] <= wdata_b;
    else if (pl_we) mem_b[pl_addr] <= pl_data;
    rdata_b <= mem_b[addr_b];
  end
  always @(posedge CLOCK_50) begin
    if (wren_c) mem_c[addr_c] <= wdata_c;
    rdata_c <= mem_c[addr_c];
  end

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      alive_m[w] = 4'b1111;
      go_m[w] = 1'b0;
      ovr_m[w] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; clear_req = 1'b0; tick_c = 1'b0; clear_c = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
  endtask

  task automatic preload(input int ad, input int val);
    pl_we = 1'b1; pl_addr = 15'(ad); pl_data = 3'(val);
    ref_mem[0][ad] = 3'(val);
    ref_mem[1][ad] = 3'(val);
    @(negedge CLOCK_50);
    pl_we = 1'b0;
  endtask

  // One tick on both default instances; extra_c pulses a second tick while busy.
  task automatic do_tick(input int px [4], input int py [4], input int extra_c);
    int fx, fy;
    int ad [4];
    bit inb [4];
    bit dies [4];
    logic [3:0] old_m [2];
    bit ew [2][13];
    int ea [2][13];
    int ed [2][13];
    logic o_we, o_draw, o_busy, o_go, o_ovr;
    logic [14:0] o_ad;
    logic [2:0] o_wd;
    logic [3:0] o_al;
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 13; c++) begin ew[w][c] = 1'b0; ea[w][c] = 0; ed[w][c] = 0; end
      for (int i = 0; i < 4; i++) begin
        fx = px[i]; fy = py[i];
        if (w == 1) begin
          if (fx == 255) fx = 159; else if (fx >= 160) fx = 0;
          if (fy == 127) fy = 119; else if (fy >= 120) fy = 0;
        end
        inb[i] = (fx < 160) && (fy < 120);
        ad[i] = fx * 128 + fy;
      end
      for (int i = 0; i < 4; i++) begin
        dies[i] = 1'b0;
        if (alive_m[w][i]) begin
          if (ref_mem[w][ad[i]] != 3'd0) dies[i] = 1'b1;
          if (w == 0 && !inb[i]) dies[i] = 1'b1;
          for (int j = 0; j < 4; j++)
            if (j != i && alive_m[w][j] && ad[j] == ad[i]) dies[i] = 1'b1;
        end
      end
      old_m[w] = alive_m[w];
      for (int k = 0; k < 4; k++) begin
        if (alive_m[w][k] && !dies[k]) begin ew[w][7+k] = 1'b1; ea[w][7+k] = ad[k]; ed[w][7+k] = k + 1; end
        else if (alive_m[w][k] && inb[k]) begin ew[w][7+k] = 1'b1; ea[w][7+k] = ad[k]; ed[w][7+k] = 7; end
        if (dies[k]) alive_m[w][k] = 1'b0;
      end
      for (int c = 7; c <= 10; c++) if (ew[w][c]) ref_mem[w][ea[w][c]] = 3'(ed[w][c]);
      if ($countones(alive_m[w]) <= 1) go_m[w] = 1'b1;
      if (extra_c >= 1 && extra_c <= 11) ovr_m[w] = 1'b1;
    end
    for (int i = 0; i < 4; i++) pos_ab[i*15 +: 15] = 15'(px[i] * 128 + py[i]);
    tick = 1'b1;
    @(negedge CLOCK_50);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge CLOCK_50);
      tick = (c == extra_c);
      for (int w = 0; w < 2; w++) begin
        o_we = w ? wren_b : wren_a;   o_ad = w ? addr_b : addr_a;   o_wd = w ? wdata_b : wdata_a;
        o_draw = w ? draw_b : draw_a; o_busy = w ? busy_b : busy_a; o_al = w ? alive_b : alive_a;
        o_go = w ? go_b : go_a;       o_ovr = w ? ovr_b : ovr_a;
        total++;
        if (o_we !== ew[w][c]) begin
          bad++; $display("FAIL wren w=%0d c=%0d got=%b want=%b", w, c, o_we, ew[w][c]);
        end else if (ew[w][c]) begin
          total++;
          if (o_ad !== 15'(ea[w][c]) || o_wd !== 3'(ed[w][c])) begin
            bad++; $display("FAIL write w=%0d c=%0d got=%h/%0d want=%h/%0d", w, c, o_ad, o_wd, ea[w][c], ed[w][c]);
          end
        end
        total++;
        if (o_draw !== (c == 11)) begin bad++; $display("FAIL draw_start w=%0d c=%0d got=%b", w, c, o_draw); end
        total++;
        if (o_busy !== (c <= 11)) begin bad++; $display("FAIL busy w=%0d c=%0d got=%b", w, c, o_busy); end
        if (c == 10) begin
          total++;
          if (o_al !== old_m[w]) begin bad++; $display("FAIL alive_early w=%0d got=%b want=%b", w, o_al, old_m[w]); end
        end
        if (c == 11) begin
          total++;
          if (o_al !== alive_m[w]) begin bad++; $display("FAIL alive w=%0d got=%b want=%b", w, o_al, alive_m[w]); end
          total++;
          if (o_go !== go_m[w]) begin bad++; $display("FAIL game_over w=%0d got=%b want=%b", w, o_go, go_m[w]); end
          total++;
          if (o_ovr !== ovr_m[w]) begin bad++; $display("FAIL overrun w=%0d got=%b want=%b", w, o_ovr, ovr_m[w]); end
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLOCK_50);
    total++;
    if ({addr_a, wdata_a, wren_a, busy_a, draw_a, go_a, ovr_a, alive_a} !== {15'd0, 3'd0, 5'd0, 4'b1111}) begin
      bad++; $display("FAIL reset_a got=%h", {addr_a, wdata_a, wren_a, busy_a, draw_a, go_a, ovr_a, alive_a});
    end
    total++;
    if ({addr_c, wdata_c, wren_c, busy_c, draw_c, go_c, ovr_c, alive_c} !== {5'd0, 3'd0, 5'd0, 4'b1111}) begin
      bad++; $display("FAIL reset_c got=%h", {addr_c, wdata_c, wren_c, busy_c, draw_c, go_c, ovr_c, alive_c});
    end
    do_reset();
    total++;
    if ({busy_b, draw_b, wren_b, alive_b} !== {3'd0, 4'b1111}) begin
      bad++; $display("FAIL idle_b got=%b", {busy_b, draw_b, wren_b, alive_b});
    end
  endtask

  task automatic test_basic_and_back_to_back();
    int px [4]; int py [4];
    px = '{10, 20, 30, 40}; py = '{10, 20, 30, 40};
    do_tick(px, py, 0);
    px = '{11, 21, 31, 41};
    do_tick(px, py, 0);
    px = '{12, 10, 32, 42}; py = '{10, 10, 30, 40};
    do_tick(px, py, 0);
  endtask

  task automatic test_trail_and_head_on();
    int px [4]; int py [4];
    do_reset();
    preload(70 * 128 + 70, 2);
    px = '{70, 80, 90, 100}; py = '{70, 80, 90, 100};
    do_tick(px, py, 0);
    do_reset();
    px = '{15, 50, 50, 25}; py = '{90, 60, 60, 90};
    do_tick(px, py, 0);
  endtask

  task automatic test_wrap_and_game_over();
    int px [4]; int py [4];
    do_reset();
    px = '{12, 22, 32, 255}; py = '{100, 100, 100, 5};
    do_tick(px, py, 0);
    px = '{13, 23, 33, 200}; py = '{100, 100, 100, 127};
    do_tick(px, py, 0);
    do_reset();
    px = '{60, 60, 60, 61}; py = '{30, 30, 30, 30};
    do_tick(px, py, 0);
  endtask

  task automatic test_overrun_and_random();
    int px [4]; int py [4]; int r;
    do_reset();
    px = '{100, 110, 120, 130}; py = '{50, 50, 50, 50};
    do_tick(px, py, 4);
    for (int t = 0; t < 12; t++) begin
      if (t % 4 == 0) do_reset();
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 11);
        px[i] = (r == 0) ? 255 : (r == 1) ? 170 : 140 + $urandom_range(0, 4);
        r = $urandom_range(0, 11);
        py[i] = (r == 0) ? 127 : (r == 1) ? 122 : 10 + $urandom_range(0, 3);
      end
      do_tick(px, py, (t % 3 == 0) ? $urandom_range(2, 10) : 0);
    end
  endtask

  task automatic test_reset_mid();
    pos_ab = {15'(5 * 128 + 100), 15'(6 * 128 + 100), 15'(7 * 128 + 100), 15'(8 * 128 + 100)};
    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    total++;
    if ({wren_a, busy_a, alive_a, wren_b, busy_b, alive_b} !== {2'b00, 4'b1111, 2'b00, 4'b1111}) begin
      bad++; $display("FAIL reset_mid got=%b", {wren_a, busy_a, alive_a, wren_b, busy_b, alive_b});
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
  endtask

  task automatic test_clear();
    bit found;
    int nz;
    pos_c = {5'b010_10, 5'b001_01, 5'b001_01, 5'b001_01};
    tick_c = 1'b1;
    @(negedge CLOCK_50);
    found = 1'b0;
    for (int c = 1; c <= 30 && !found; c++) begin
      if (c > 1) @(negedge CLOCK_50);
      tick_c = (c == 3);
      if (draw_c === 1'b1) found = 1'b1;
    end
    tick_c = 1'b0;
    total++;
    if (!found) begin bad++; $display("FAIL c_tick_timeout got=none want=draw_start"); end
    @(negedge CLOCK_50);
    total++;
    if ({alive_c, go_c, ovr_c, mem_c[5], mem_c[10]} !== {4'b1000, 2'b11, 3'd7, 3'd4}) begin
      bad++; $display("FAIL c_kill got=%b want=%b", {alive_c, go_c, ovr_c, mem_c[5], mem_c[10]}, {4'b1000, 2'b11, 3'd7, 3'd4});
    end
    clear_c = 1'b1;
    tick_c = 1'b1;
    @(negedge CLOCK_50);
    clear_c = 1'b0;
    tick_c = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) @(negedge CLOCK_50);
      total++;
      if (c <= 32) begin
        if ({busy_c, draw_c, wren_c, addr_c, wdata_c} !== {3'b101, 5'(c - 1), 3'd0}) begin
          bad++; $display("FAIL clear_write c=%0d got=%b", c, {busy_c, draw_c, wren_c, addr_c, wdata_c});
        end
      end else if (c == 33) begin
        if ({busy_c, draw_c, wren_c, alive_c, go_c, ovr_c} !== {3'b110, 4'b1111, 2'b00}) begin
          bad++; $display("FAIL clear_done got=%b", {busy_c, draw_c, wren_c, alive_c, go_c, ovr_c});
        end
      end else begin
        if ({busy_c, draw_c} !== 2'b00) begin bad++; $display("FAIL clear_idle got=%b", {busy_c, draw_c}); end
      end
    end
    nz = 0;
    for (int a = 0; a < 32; a++) if (mem_c[a] != 3'd0) nz++;
    total++;
    if (nz != 0) begin bad++; $display("FAIL clear_board nonzero=%0d want=0", nz); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_and_back_to_back();
    test_trail_and_head_on();
    test_wrap_and_game_over();
    test_overrun_and_random();
    test_reset_mid();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arena_tick_engine.md
# arena_tick_engine

Parametrised per-tick board update engine for the N-player light-cycle game. On each movement tick it latches every player's new position and reads the occupied colour at each position from the board RAM. It then resolves deaths (trail hit, head-on collision, arena edge), writes trail or collision colours back, and pulses the VGA drawer. It sits between the player mover / rate divider and the single-port board RAM, owns the alive flags, and also clears the whole board for a new game.

## Interface
Parameters:
- NUM_PLAYERS, 4: player count, 2..(2^COLOR_BITS-2).
- X_BITS, 8: X coordinate width.
- Y_BITS, 7: Y coordinate width.
- X_MAX, 160: arena width; legal X is 0..X_MAX-1; requires X_MAX < 2^X_BITS.
- Y_MAX, 120: arena height; legal Y is 0..Y_MAX-1; requires Y_MAX < 2^Y_BITS.
- COLOR_BITS, 3: RAM data width.
- WRAP_MODE, 0: 0 = leaving the arena kills the player; 1 = coordinates fold to the opposite edge.

Ports (AW = X_BITS+Y_BITS, PW = X_BITS+Y_BITS):
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- tick  in  1  one-cycle movement pulse from the rate divider.
- clear_req  in  1  request a board wipe plus revival of all players.
- pos_in  in  NUM_PLAYERS*PW  player i occupies bits [i*PW +: PW] as {x, y}.
- ram_rdata  in  COLOR_BITS  RAM q.
- ram_addr  out  AW  registered; {x, y}.
- ram_wdata  out  COLOR_BITS  registered.
- ram_wren  out  1  registered.
- alive_out  out  NUM_PLAYERS  bit i = player i alive.
- busy  out  1  high in any state other than IDLE.
- draw_start  out  1  one-cycle pulse when a tick or clear completes.
- game_over  out  1  sticky; set when alive count is 1 or fewer after a tick.
- overrun  out  1  sticky; set when tick arrives while busy.

## Operation
- States: IDLE, READ, CHECK, WRITE, DONE, CLEAR.
- IDLE:
  - clear_req has priority over a simultaneous tick; the tick is dropped without setting overrun.
  - On tick: latch pos_in into per-player registers, applying the fold when WRAP_MODE=1, then go to READ.
  - Fold rule, per axis: value all-ones becomes MAX-1; any other value ≥ MAX becomes 0.
- READ, N+1 cycles (N = NUM_PLAYERS):
  - Cycle k < N drives ram_addr = position of player k with ram_wren=0.
  - Cycle k ≥ 1 captures ram_rdata as occ[k-1].
- CHECK, 1 cycle. A player alive at latch dies if any of:
  - occ != 0;
  - its position equals another player's position, where that other player was also alive at latch;
  - WRAP_MODE=0 and x ≥ X_MAX or y ≥ Y_MAX.
- Dead players at latch are ignored everywhere: no read-collision effect and no write.
- WRITE, N cycles; cycle k handles player k:
  - Alive at latch and survives: write colour k+1.
  - Died in bounds: write all-ones (collision colour).
  - Died out of bounds, or dead at latch: ram_wren=0.
- DONE, 1 cycle:
  - alive_out updated with the new alive mask.
  - draw_start=1.
  - game_over set if popcount(new alive) ≤ 1.
  - Return to IDLE.
- CLEAR:
  - Write 0 to addresses 0..2^AW-1, one per cycle, in ascending order.
  - Then go to DONE: alive_out becomes all ones, game_over clears, overrun clears, draw_start pulses.
- overrun is set when tick=1 in any state other than IDLE; that tick is otherwise ignored.

## Timing
- Reset values:
  - ram_addr=0, ram_wdata=0, ram_wren=0.
  - busy=0, draw_start=0, game_over=0, overrun=0.
  - alive_out = all ones; state IDLE.
- Reset mid-operation aborts the sequence immediately. Partial RAM writes are not undone.
- RAM read latency: an address driven in cycle t yields q sampled at the end of cycle t+1.
- Tick sequence, with tick sampled at the edge ending cycle 0:
  - READ occupies cycles 1..N+1, CHECK cycle N+2, WRITE cycles N+3..2N+2, DONE cycle 2N+3.
  - busy is high in cycles 1..2N+3; draw_start is high in cycle 2N+3.
  - alive_out reflects the new mask from cycle 2N+3.
  - With N=4: draw_start in cycle 11.
- Clear sequence: busy is high for 2^AW+1 cycles; draw_start rises in the last of those cycles.
- A new tick is accepted in the first IDLE cycle after DONE.

## Test plan
- N=4, empty RAM, positions (10,10), (20,20), (30,30), (40,40), tick:
  - Writes colours 1, 2, 3, 4 at those addresses in cycles 7..10.
  - draw_start in cycle 11; alive_out=4'b1111.
- RAM preloaded with 3'b010 at (10,10), player 0 moves there:
  - alive_out=4'b1110; 3'b111 written at (10,10); others write normally.
- Players 1 and 2 both at (50,60) on an empty board:
  - Both die; 3'b111 written twice at (50,60); alive_out=4'b1001.
- WRAP_MODE=0 with player 3 at x=255, then WRAP_MODE=1 with the same stimulus:
  - WRAP_MODE=0: player 3 dies with no write.
  - WRAP_MODE=1: colour 4 is written at (159, y).
- Kill players until one remains: game_over=1.
  - Then clear_req with X_BITS=3, Y_BITS=2: writes 0 to addresses 0..31, alive_out=all ones, game_over=0.
- tick while busy sets overrun=1. Assert reset in cycle 5 of a tick: ram_wren=0, busy=0, alive_out=all ones immediately.
